stream_mux_nto1: RTL and testbench

//  Registered N-to-1 stream multiplexer with valid/ready handshake, for merging AdaIN

---
 rtl/stream_mux_nto1_pkg.sv | 25 ++
 rtl/stream_mux_nto1_rr_arbiter.sv | 46 ++++
 rtl/stream_mux_nto1.sv | 157 +++++++++++++++
 tb/tb_stream_mux_nto1.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_nto1_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_pkg
//  Brief    : Shared types, arbitration-mode constants and select-width helper
//             for the stream_mux_nto1 multiplexer.
//  Revision : 1.0 - initial release
// ============================================================================
package stream_mux_pkg;

    // Mux control states: arbitrate in IDLE, stream a burst in GRANT.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int ARB_EXT = 0;
    localparam int ARB_RR  = 1;

    // Select width for an n-way choice; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_nto1_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter_n
//  Brief    : Combinational round-robin picker. Returns the first asserted
//             request found searching upward from ptr+1 with wrap-around.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_n
    import stream_mux_pkg::*;
#(
    parameter int N    = 5,
    parameter int SELW = sel_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    // One spare bit so ptr + k never overflows before the wrap subtraction.
    localparam logic [SELW:0] c_n_ext = (SELW + 1)'(N);

    logic [SELW:0]   w_sum;
    logic [SELW-1:0] w_pos;

    // Walk the ring from ptr+1; the first hit claims the grant.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = 1; k <= N; k++) begin
            w_sum = {1'b0, ptr} + (SELW + 1)'(k);
            if (w_sum >= c_n_ext) begin
                w_sum = w_sum - c_n_ext;
            end
            w_pos = w_sum[SELW-1:0];
            if (!gnt_any && req[w_pos]) begin
                gnt_any = 1'b1;
                gnt_idx = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_mux_nto1.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_nto1
//  Brief    : Registered N-to-1 valid/ready stream multiplexer. A grant is held
//             for BURST_LEN beats; the channel is taken from sel or from a
//             round-robin arbiter. Output data always comes from a flop.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_mux_nto1
    import stream_mux_pkg::*;
#(
    parameter  int N         = 5,
    parameter  int WIDTH     = 16,
    parameter  int BURST_LEN = 1,
    parameter  int ARB_MODE  = 0,
    localparam int SELW      = sel_w(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SELW-1:0]      sel,
    input  logic [N-1:0]         s_valid,
    input  logic [N*WIDTH-1:0]   s_data,
    output logic [N-1:0]         s_ready,
    output logic                 m_valid,
    output logic [WIDTH-1:0]     m_data,
    input  logic                 m_ready,
    output logic [SELW-1:0]      m_chan,
    output logic                 m_last,
    output logic                 busy
);

    localparam int                  c_cnt_w     = $clog2(BURST_LEN + 1);
    localparam logic [c_cnt_w-1:0]  c_last_beat = c_cnt_w'(BURST_LEN - 1);
    localparam logic [SELW:0]       c_n_ext     = (SELW + 1)'(N);
    localparam logic [SELW-1:0]     c_ptr_rst   = SELW'(N - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SELW-1:0]      r_gnt;
    logic [c_cnt_w-1:0]   r_beat_cnt;
    logic [SELW-1:0]      r_rr_ptr;

    logic                 r_m_valid;
    logic [WIDTH-1:0]     r_m_data;
    logic [SELW-1:0]      r_m_chan;
    logic                 r_m_last;

    logic [SELW-1:0]      w_rr_idx;
    logic                 w_rr_any;
    logic [SELW-1:0]      w_arb_idx;
    logic                 w_arb_any;
    logic                 w_out_free;
    logic                 w_accept;
    logic                 w_last_beat;

    rr_arbiter_n #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req     (s_valid),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_rr_idx),
        .gnt_any (w_rr_any)
    );

    // Arbitration source: external select (ignored when out of range) or round-robin.
    always_comb begin
        w_arb_idx = '0;
        w_arb_any = 1'b0;
        if (ARB_MODE == ARB_RR) begin
            w_arb_idx = w_rr_idx;
            w_arb_any = w_rr_any;
        end else begin
            w_arb_idx = sel;
            w_arb_any = ({1'b0, sel} < c_n_ext);
        end
    end

    // Output register can take a new beat when empty or draining this cycle.
    always_comb begin
        w_out_free  = !r_m_valid || m_ready;
        w_accept    = (r_state == GRANT) && s_valid[r_gnt] && w_out_free;
        w_last_beat = (r_beat_cnt == c_last_beat);
    end

    // Only the granted channel ever sees ready, and only while in GRANT.
    always_comb begin
        s_ready = '0;
        if ((r_state == GRANT) && w_out_free) begin
            s_ready[r_gnt] = 1'b1;
        end
    end

    // Next state: one IDLE cycle per arbitration, back to IDLE after the last beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_arb_any) w_state_nxt = GRANT;
            GRANT:   if (w_accept && w_last_beat) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant latch, beat counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt      <= '0;
            r_beat_cnt <= '0;
            r_rr_ptr   <= c_ptr_rst;
        end else if (r_state == IDLE) begin
            if (w_arb_any) begin
                r_gnt <= w_arb_idx;
            end
        end else if (w_accept) begin
            if (w_last_beat) begin
                r_beat_cnt <= '0;
                r_rr_ptr   <= r_gnt;
            end else begin
                r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
            end
        end
    end

    // Output stage: reload on accept, drop valid when drained, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_chan  <= '0;
            r_m_last  <= 1'b0;
        end else if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_data  <= s_data[r_gnt*WIDTH +: WIDTH];
            r_m_chan  <= r_gnt;
            r_m_last  <= w_last_beat;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_chan  = r_m_chan;
    assign m_last  = r_m_last;
    assign busy    = (r_state == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_nto1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_mux_nto1
//  Brief    : Self-checking bench for stream_mux_nto1. Three instances:
//             d0 external select / 4-beat bursts, d1 round-robin / 1 beat,
//             d2 round-robin / 4-beat bursts. A transaction-level model
//             predicts ready, busy and the output register every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_nto1;

    localparam int N  = 5;
    localparam int W  = 16;
    localparam int ND = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [ND-1:0][2:0]     sel;
    logic [ND-1:0][N-1:0]   sv;
    logic [ND-1:0][N*W-1:0] sd;
    logic [ND-1:0]          mr;
    logic [ND-1:0][N-1:0]   sr;
    logic [ND-1:0]          mv;
    logic [ND-1:0][W-1:0]   md;
    logic [ND-1:0][2:0]     mc;
    logic [ND-1:0]          ml;
    logic [ND-1:0]          bz;

    int checks = 0;
    int errors = 0;

    // Reference model state per instance.
    int         bl   [ND] = '{4, 1, 4};
    int         mode [ND] = '{0, 1, 1};
    bit         m_idle [ND];
    int         m_g    [ND];
    int         m_cnt  [ND];
    int         m_rrp  [ND];
    logic       m_v    [ND];
    logic [W-1:0] m_d  [ND];
    int         m_c    [ND];
    logic       m_l    [ND];

    bit         seq_data = 1'b0;
    int         focus    = -1;
    int         obs_q[$];
    bit         acc_q[$];
    int         exp_a [6] = '{0, 1, 2, 3, 4, 0};
    int         exp_b [4] = '{1, 4, 1, 4};

    always #5 clk = ~clk;

    stream_mux_nto1 #(.N(N), .WIDTH(W), .BURST_LEN(4), .ARB_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sel(sel[0]), .s_valid(sv[0]), .s_data(sd[0]),
        .s_ready(sr[0]), .m_valid(mv[0]), .m_data(md[0]), .m_ready(mr[0]),
        .m_chan(mc[0]), .m_last(ml[0]), .busy(bz[0]));

    stream_mux_nto1 #(.N(N), .WIDTH(W), .BURST_LEN(1), .ARB_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sel(sel[1]), .s_valid(sv[1]), .s_data(sd[1]),
        .s_ready(sr[1]), .m_valid(mv[1]), .m_data(md[1]), .m_ready(mr[1]),
        .m_chan(mc[1]), .m_last(ml[1]), .busy(bz[1]));

    stream_mux_nto1 #(.N(N), .WIDTH(W), .BURST_LEN(4), .ARB_MODE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .sel(sel[2]), .s_valid(sv[2]), .s_data(sd[2]),
        .s_ready(sr[2]), .m_valid(mv[2]), .m_data(md[2]), .m_ready(mr[2]),
        .m_chan(mc[2]), .m_last(ml[2]), .busy(bz[2]));

    task automatic check(input string tag, input int d, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[d%0d]: observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    // First requesting channel after p, going round the ring.
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic reset_model();
        for (int d = 0; d < ND; d++) begin
            m_idle[d] = 1'b1;
            m_g[d]    = 0;
            m_cnt[d]  = 0;
            m_rrp[d]  = N - 1;
            m_v[d]    = 1'b0;
            m_d[d]    = '0;
            m_c[d]    = 0;
            m_l[d]    = 1'b0;
        end
    endtask

    // Assert reset at a falling edge and check outputs clear immediately.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            check("rst_s_ready", d, 32'(sr[d]), 32'd0);
            check("rst_busy",    d, 32'(bz[d]), 32'd0);
            check("rst_m_valid", d, 32'(mv[d]), 32'd0);
            check("rst_m_data",  d, 32'(md[d]), 32'd0);
            check("rst_m_chan",  d, 32'(mc[d]), 32'd0);
            check("rst_m_last",  d, 32'(ml[d]), 32'd0);
        end
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: check combinational outputs, step the model, check registers.
    task automatic cycle();
        bit           acc  [ND];
        int           gacc [ND];
        logic [N-1:0] esr;
        int           p;
        #1;
        for (int d = 0; d < ND; d++) begin
            esr = '0;
            if (!m_idle[d] && (!m_v[d] || mr[d])) esr = N'(1 << m_g[d]);
            check("s_ready", d, 32'(sr[d]), 32'(esr));
            check("busy",    d, 32'(bz[d]), 32'(!m_idle[d]));
            acc[d]  = !m_idle[d] && sv[d][m_g[d]] && (esr != '0);
            gacc[d] = m_g[d];
            if (d == focus) begin
                acc_q.push_back(|(sv[d] & sr[d]));
                if (mv[d] && mr[d])
                    obs_q.push_back((32'(ml[d]) << 20) | (32'(mc[d]) << 16) | 32'(md[d]));
            end
            if (acc[d]) begin
                m_v[d] = 1'b1;
                m_d[d] = sd[d][m_g[d]*W +: W];
                m_c[d] = m_g[d];
                m_l[d] = (m_cnt[d] == bl[d] - 1);
                if (m_l[d]) begin
                    m_cnt[d]  = 0;
                    m_rrp[d]  = m_g[d];
                    m_idle[d] = 1'b1;
                end else begin
                    m_cnt[d]++;
                end
            end else begin
                if (mr[d]) m_v[d] = 1'b0;
                if (m_idle[d]) begin
                    if (mode[d] == 0) begin
                        if (sel[d] < N) begin
                            m_g[d]    = int'(sel[d]);
                            m_idle[d] = 1'b0;
                        end
                    end else begin
                        p = rr_pick(sv[d], m_rrp[d]);
                        if (p >= 0) begin
                            m_g[d]    = p;
                            m_idle[d] = 1'b0;
                        end
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check("m_valid", d, 32'(mv[d]), 32'(m_v[d]));
            check("m_data",  d, 32'(md[d]), 32'(m_d[d]));
            check("m_chan",  d, 32'(mc[d]), 32'(m_c[d]));
            check("m_last",  d, 32'(ml[d]), 32'(m_l[d]));
            if (acc[d]) begin
                if (seq_data) sd[d][gacc[d]*W +: W] = sd[d][gacc[d]*W +: W] + 16'd1;
                else          sd[d][gacc[d]*W +: W] = 16'($urandom);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst_n = 1'b1;
        sel   = '0;
        sv    = '0;
        mr    = '1;
        for (int d = 0; d < ND; d++)
            for (int c = 0; c < N; c++) sd[d][c*W +: W] = 16'($urandom);
        sel[0] = 3'd7;
        @(negedge clk);

        // Reset with every channel requesting.
        sv = {ND{5'h1F}};
        apply_reset();
        sv = '0;

        // Out-of-range select keeps d0 idle; a valid select grants next cycle.
        run(3);
        sel[0] = 3'd3;
        cycle();
        #1;
        check("t5_grant_ch3", 0, 32'(sr[0]), 32'h08);
        check("t5_busy",      0, 32'(bz[0]), 32'd1);
        sv[0]  = 5'b01000;
        sel[0] = 3'd7;
        run(4);
        sv[0] = '0;
        run(2);

        // Sequential burst data on channel 2, continuous ready.
        focus = 0; obs_q.delete(); acc_q.delete();
        seq_data = 1'b1;
        sd[0][2*W +: W] = 16'hA001;
        sel[0] = 3'd2;
        sv[0]  = 5'b00100;
        for (int k = 0; k < 11; k++) begin
            if (k == 6)  sel[0] = 3'd7;
            if (k == 10) sv[0]  = '0;
            cycle();
        end
        for (int k = 0; k < 10; k++)
            check("t2_accept_pattern", k, 32'(acc_q[k]), 32'((k % 5) != 0));
        check("t2_beat_count", 0, 32'(obs_q.size()), 32'd8);
        for (int i = 0; i < obs_q.size() && i < 8; i++)
            check("t2_beat", i, 32'(obs_q[i]),
                  (32'((i % 4) == 3) << 20) | (32'd2 << 16) | (32'hA001 + 32'(i)));

        // Backpressure for three cycles in the middle of a burst.
        obs_q.delete();
        sd[0][1*W +: W] = 16'hB001;
        sel[0] = 3'd1;
        sv[0]  = 5'b00010;
        cycle();
        sel[0] = 3'd7;
        run(2);
        mr[0] = 1'b0;
        run(3);
        check("t4_hold_data", 0, 32'(md[0]), 32'hB002);
        check("t4_hold_chan", 0, 32'(mc[0]), 32'd1);
        check("t4_hold_last", 0, 32'(ml[0]), 32'd0);
        mr[0] = 1'b1;
        run(2);
        sv[0] = '0;
        run(2);
        check("t4_beat_count", 0, 32'(obs_q.size()), 32'd4);
        for (int i = 0; i < obs_q.size() && i < 4; i++)
            check("t4_beat", i, 32'(obs_q[i]),
                  (32'(i == 3) << 20) | (32'd1 << 16) | (32'hB001 + 32'(i)));

        // Round-robin, single-beat bursts.
        seq_data = 1'b0;
        focus = 1; obs_q.delete();
        sv[1] = 5'h1F;
        run(12);
        sv[1] = '0;
        run(2);
        check("t3_all_count", 1, 32'(obs_q.size()), 32'd6);
        for (int i = 0; i < obs_q.size() && i < 6; i++)
            check("t3_all_chan", i, 32'((obs_q[i] >> 16) & 7), 32'(exp_a[i]));
        obs_q.delete();
        sv[1] = 5'b10010;
        run(8);
        sv[1] = '0;
        run(2);
        check("t3_sparse_count", 1, 32'(obs_q.size()), 32'd4);
        for (int i = 0; i < obs_q.size() && i < 4; i++)
            check("t3_sparse_chan", i, 32'((obs_q[i] >> 16) & 7), 32'(exp_b[i]));

        // Randomized traffic on all instances against the model.
        focus = -1;
        for (int k = 0; k < 400; k++) begin
            sel[0] = 3'($urandom_range(7, 0));
            for (int d = 0; d < ND; d++) sv[d] = 5'($urandom);
            mr = 3'($urandom);
            cycle();
        end
        sel[0] = 3'd7;
        sv = {ND{5'h1F}};
        mr = '1;
        run(10);
        sv = '0;
        run(4);

        // Reset in the middle of the second burst, then a fresh arbitration.
        apply_reset();
        focus = 2; obs_q.delete();
        sv[2] = 5'h1F;
        run(8);
        check("t6_inflight_chan", 2, 32'(mc[2]), 32'd1);
        apply_reset();
        obs_q.delete();
        cycle();
        #1;
        check("t6_restart_ready", 2, 32'(sr[2]), 32'h01);
        run(4);
        sv[2] = '0;
        run(3);
        check("t6_restart_count", 2, 32'(obs_q.size()), 32'd4);
        if (obs_q.size() > 0)
            check("t6_restart_chan", 2, 32'((obs_q[0] >> 16) & 7), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
